// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//   First-word-fall-through buffer for ALU results awaiting writeback. Each
//   entry holds {BusW, Zero, Rd, RegWrite}. RegWrite is forced to 0 on entry
//   when Rd addresses register 31 (XZR).
//
//   Optional feature (macro ALU_RESULT_FWD_EN): combinational forwarding lookup.
//   FwdHit/FwdData report the youngest occupied entry that writes FwdRn.
//   Without the macro, FwdHit/FwdData are tied to 0 and FwdRn is ignored.
//
// Ports
//   CLK, Reset                  clock; synchronous active-high reset
//   InValid/InReady             push handshake; InReady depends on state only
//   BusW, Zero, Rd, RegWrite    incoming ALU result
//   OutValid/OutReady           pop handshake for the head entry
//   OutBusW/OutZero/OutRd/OutRegWrite  head entry fields; 0 while empty
//   Count                       number of occupied entries
//   FwdRn, FwdHit, FwdData      forwarding lookup

module alu_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RW    = 5
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [63:0]              BusW,
  input  logic                     Zero,
  input  logic [RW-1:0]            Rd,
  input  logic                     RegWrite,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [63:0]              OutBusW,
  output logic                     OutZero,
  output logic [RW-1:0]            OutRd,
  output logic                     OutRegWrite,
  output logic [$clog2(DEPTH):0]   Count,
  input  logic [RW-1:0]            FwdRn,
  output logic                     FwdHit,
  output logic [63:0]              FwdData
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [63:0]   busw_q  [DEPTH];
  logic          zero_q  [DEPTH];
  logic [RW-1:0] rd_q    [DEPTH];
  logic          regw_q  [DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic push, pop;
  logic regw_in;

  assign InReady  = (count_q < FullCount);
  assign OutValid = (count_q != '0);
  assign Count    = count_q;

  assign push = InValid && InReady;
  assign pop  = OutValid && OutReady;

  // Writes to XZR are never written back.
  assign regw_in = RegWrite && (Rd != '1);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        busw_q[wr_ptr_q] <= BusW;
        zero_q[wr_ptr_q] <= Zero;
        rd_q[wr_ptr_q]   <= Rd;
        regw_q[wr_ptr_q] <= regw_in;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Head fields are masked so stale storage never leaks out while empty.
  always_comb begin
    OutBusW     = '0;
    OutZero     = 1'b0;
    OutRd       = '0;
    OutRegWrite = 1'b0;
    if (OutValid) begin
      OutBusW     = busw_q[rd_ptr_q];
      OutZero     = zero_q[rd_ptr_q];
      OutRd       = rd_q[rd_ptr_q];
      OutRegWrite = regw_q[rd_ptr_q];
    end
  end

`ifdef ALU_RESULT_FWD_EN
  // Walk from oldest to youngest; a later match overrides an earlier one so
  // the youngest matching entry wins. Same-cycle pushes are not visible.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    FwdHit  = 1'b0;
    FwdData = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && regw_q[idx] && (rd_q[idx] == FwdRn)) begin
        FwdHit  = 1'b1;
        FwdData = busw_q[idx];
      end
    end
  end
`else
  logic unused_fwd_rn;
  assign unused_fwd_rn = ^FwdRn;
  assign FwdHit        = 1'b0;
  assign FwdData       = '0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;

  logic        CLK = 1'b0;
  logic        Reset, InValid, InReady, Zero, RegWrite;
  logic [63:0] BusW;
  logic [4:0]  Rd;
  logic        OutValid, OutReady, OutZero, OutRegWrite;
  logic [63:0] OutBusW;
  logic [4:0]  OutRd;
  logic [2:0]  Count;
  logic [4:0]  FwdRn;
  logic        FwdHit;
  logic [63:0] FwdData;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_result_buffer #(.DEPTH(4), .RW(5)) dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .BusW(BusW), .Zero(Zero), .Rd(Rd), .RegWrite(RegWrite),
    .OutValid(OutValid), .OutReady(OutReady), .OutBusW(OutBusW),
    .OutZero(OutZero), .OutRd(OutRd), .OutRegWrite(OutRegWrite),
    .Count(Count), .FwdRn(FwdRn), .FwdHit(FwdHit), .FwdData(FwdData)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [63:0] busw;
    logic        zero;
    logic [4:0]  rd;
    logic        rw;
    logic        ordy;
    logic [2:0]  e_cnt;
    logic        e_ir;
    logic        e_ov;
    logic [63:0] e_busw;
    logic        e_zero;
    logic [4:0]  e_rd;
    logic        e_rw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic iv, logic [63:0] busw, logic zero,
                              logic [4:0] rd, logic rw, logic ordy, logic [2:0] e_cnt,
                              logic e_ir, logic e_ov, logic [63:0] e_busw, logic e_zero,
                              logic [4:0] e_rd, logic e_rw);
    vec_t v;
    v.rst = rst; v.iv = iv; v.busw = busw; v.zero = zero; v.rd = rd; v.rw = rw;
    v.ordy = ordy; v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_ov = e_ov; v.e_busw = e_busw;
    v.e_zero = e_zero; v.e_rd = e_rd; v.e_rw = e_rw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [63:0] busw,
                       input logic zero, input logic [4:0] rd, input logic rw,
                       input logic ordy);
    Reset = rst; InValid = iv; BusW = busw; Zero = zero; Rd = rd; RegWrite = rw;
    OutReady = ordy;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    FwdRn = 5'd0;

    //       rst iv busw     z rd  rw or | cnt ir ov busw     z rd  rw
    vecs.push_back(mk(1, 0, 64'h0,    0, 0,  0, 0,  0, 1, 0, 64'h0,    0, 0,  0));
    vecs.push_back(mk(0, 1, 64'h1234, 0, 3,  1, 0,  1, 1, 1, 64'h1234, 0, 3,  1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0,  0, 1,  0, 1, 0, 64'h0,    0, 0,  0));
    vecs.push_back(mk(0, 1, 64'd1,    0, 1,  1, 0,  1, 1, 1, 64'd1,    0, 1,  1));
    vecs.push_back(mk(0, 1, 64'd2,    0, 2,  1, 0,  2, 1, 1, 64'd1,    0, 1,  1));
    vecs.push_back(mk(0, 1, 64'd3,    0, 3,  1, 0,  3, 1, 1, 64'd1,    0, 1,  1));
    vecs.push_back(mk(0, 1, 64'd4,    0, 4,  1, 0,  4, 0, 1, 64'd1,    0, 1,  1));
    // Full: push refused, nothing overwritten.
    vecs.push_back(mk(0, 1, 64'h99,   1, 7,  1, 0,  4, 0, 1, 64'd1,    0, 1,  1));
    // Full with pop: value 5 dropped.
    vecs.push_back(mk(0, 1, 64'd5,    0, 5,  1, 1,  3, 1, 1, 64'd2,    0, 2,  1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0,  0, 1,  2, 1, 1, 64'd3,    0, 3,  1));
    // Rd=31 with RegWrite=1, concurrent with a pop.
    vecs.push_back(mk(0, 1, 64'h55,   1, 31, 1, 1,  2, 1, 1, 64'd4,    0, 4,  1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0,  0, 1,  1, 1, 1, 64'h55,   1, 31, 0));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0,  0, 1,  0, 1, 0, 64'h0,    0, 0,  0));
    // OutReady while empty is ignored.
    vecs.push_back(mk(0, 0, 64'h0,    0, 0,  0, 1,  0, 1, 0, 64'h0,    0, 0,  0));
    vecs.push_back(mk(0, 1, 64'ha1,   0, 1,  0, 0,  1, 1, 1, 64'ha1,   0, 1,  0));
    vecs.push_back(mk(0, 1, 64'ha2,   0, 2,  1, 0,  2, 1, 1, 64'ha1,   0, 1,  0));
    vecs.push_back(mk(0, 1, 64'ha3,   0, 3,  1, 0,  3, 1, 1, 64'ha1,   0, 1,  0));
    // Reset with Count=3 and a concurrent push.
    vecs.push_back(mk(1, 1, 64'ha4,   0, 4,  1, 0,  0, 1, 0, 64'h0,    0, 0,  0));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0,  0, 0,  0, 1, 0, 64'h0,    0, 0,  0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].busw, vecs[i].zero, vecs[i].rd, vecs[i].rw,
            vecs[i].ordy);
      tick();
      chk($sformatf("v%0d Count", i), 64'(Count), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d InReady", i), 64'(InReady), 64'(vecs[i].e_ir));
      chk($sformatf("v%0d OutValid", i), 64'(OutValid), 64'(vecs[i].e_ov));
      chk($sformatf("v%0d OutBusW", i), OutBusW, vecs[i].e_busw);
      chk($sformatf("v%0d OutZero", i), 64'(OutZero), 64'(vecs[i].e_zero));
      chk($sformatf("v%0d OutRd", i), 64'(OutRd), 64'(vecs[i].e_rd));
      chk($sformatf("v%0d OutRegWrite", i), 64'(OutRegWrite), 64'(vecs[i].e_rw));
      chk($sformatf("v%0d FwdHit", i), 64'(FwdHit), 64'd0);
    end

    // Streaming push+pop of 1..10; pointers wrap 2.5 times over DEPTH=4.
    for (int i = 0; i <= 10; i++) begin
      drive(1'b0, (i < 10), 64'(i + 1), 1'b0, 5'd1, 1'b1, 1'b1);
      tick();
      if (i < 10) begin
        chk($sformatf("stream%0d OutBusW", i), OutBusW, 64'(i + 1));
        chk($sformatf("stream%0d Count", i), 64'(Count), 64'd1);
      end else begin
        chk("stream drained Count", 64'(Count), 64'd0);
        chk("stream drained OutValid", 64'(OutValid), 64'd0);
      end
    end

    // Forwarding lookup: two writes to register 5, youngest wins.
    drive(1'b0, 1'b1, 64'hA, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 64'hB, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    FwdRn = 5'd5;
    #1;
`ifdef ALU_RESULT_FWD_EN
    chk("fwd rn5 FwdHit", 64'(FwdHit), 64'd1);
    chk("fwd rn5 FwdData", FwdData, 64'hB);
`else
    chk("fwd rn5 FwdHit", 64'(FwdHit), 64'd0);
    chk("fwd rn5 FwdData", FwdData, 64'h0);
`endif
    FwdRn = 5'd6;
    #1;
    chk("fwd rn6 FwdHit", 64'(FwdHit), 64'd0);
    chk("fwd rn6 FwdData", FwdData, 64'h0);
    chk("fwd Count", 64'(Count), 64'd2);
    chk("fwd head OutBusW", OutBusW, 64'hA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
